button_debouncer: RTL and testbench

//  Front-end conditioning for the board push-buttons (S1-S4, active-low, bouncy, asynchronous).
//  Per-button path: synchronise, debounce by stability count, detect edges, auto-repeat.

---
 rtl/button_debouncer_pkg.sv | 21 ++
 rtl/button_debouncer_channel.sv | 131 +++++++++++++
 rtl/button_debouncer.sv | 68 ++++++
 tb/tb_button_debouncer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button conditioning block.
//   - default timing constants for a 50 MHz board clock
//   - repeat FSM state encoding
//   - small elaboration helper for counter sizing
package button_debouncer_pkg;

  localparam int DB_STABLE_20MS   = 1000000;   // 20 ms stability window
  localparam int DB_REPEAT_DELAY  = 25000000;  // 0.5 s before first auto-repeat
  localparam int DB_REPEAT_PERIOD = 5000000;   // 0.1 s between auto-repeats

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// debounce_channel: one button bit.
//   2-flop synchroniser -> stability-count debounce -> edge pulses -> auto-repeat.
// Ports:
//   clk, rst        clock, async active-high reset
//   btn_n           raw pin, 0 = pressed
//   level           debounced state, 1 = pressed (registered)
//   level_nxt       value level takes at the next edge (lets the top register any_pressed in step)
//   press_pulse     1-cycle strobe in the cycle level rises
//   release_pulse   1-cycle strobe in the cycle level falls
//   repeat_pulse    1-cycle auto-repeat strobe while held (only when REPEAT_ON)
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_20MS,
  parameter int REPEAT_DELAY  = DB_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD,
  parameter bit REPEAT_ON     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic level_nxt,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic          sync1, sync2;
  logic          stable, flip;
  logic [CW-1:0] cnt, cnt_nxt;

  rpt_state_e    state, state_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic          fire;

  // Synchroniser resets to the released pin value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples disagreeing with the accepted state; any
  // agreeing sample restarts the window.
  always_comb begin
    flip      = (~sync2 != stable) && (cnt == CW'(STABLE_CYCLES - 1));
    level_nxt = stable ^ flip;
    cnt_nxt   = '0;
    if (~sync2 != stable && !flip) cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable        <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      stable        <= level_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= flip & ~stable;
      release_pulse <= flip &  stable;
    end
  end

  assign level = stable;

  // Repeat FSM. Entered on the same edge as press_pulse so the first
  // repeat lands exactly REPEAT_DELAY cycles after it. Using level_nxt for
  // the release check lets a release beat a repeat due on the same edge.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    fire      = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (flip && !stable) begin
          state_nxt = RPT_DELAY;
          rcnt_nxt  = '0;
        end
      end
      RPT_DELAY: begin
        if (rcnt == RW'(REPEAT_DELAY - 1)) begin
          fire      = 1'b1;
          state_nxt = RPT_REPEAT;
          rcnt_nxt  = '0;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      RPT_REPEAT: begin
        if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
          fire     = 1'b1;
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      default: begin
        state_nxt = RPT_IDLE;
        rcnt_nxt  = '0;
      end
    endcase
    if (!level_nxt || !REPEAT_ON) begin
      state_nxt = RPT_IDLE;
      rcnt_nxt  = '0;
      fire      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RPT_IDLE;
      rcnt         <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      rcnt         <= rcnt_nxt;
      repeat_pulse <= fire;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: conditioning for the active-low board push-buttons.
// Each bit runs through an independent debounce_channel; outputs are
// registered levels and single-cycle event strobes.
// Ports:
//   clk            system clock
//   rst            async active-high reset
//   btn_n          raw pins, 0 = pressed, asynchronous to clk
//   level          debounced state, 1 = pressed
//   press_pulse    strobe on accepted press
//   release_pulse  strobe on accepted release
//   repeat_pulse   auto-repeat strobe while held (channels enabled in REPEAT_EN)
//   any_pressed    OR of level, registered in step with level
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int                 NUM_BTN       = 4,
  parameter int                 STABLE_CYCLES = DB_STABLE_20MS,
  parameter int                 REPEAT_DELAY  = DB_REPEAT_DELAY,
  parameter int                 REPEAT_PERIOD = DB_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_EN     = NUM_BTN'(4'b0011)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic               any_pressed
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("button_debouncer: STABLE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("button_debouncer: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("button_debouncer: REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_BTN-1:0] level_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_ON     (REPEAT_EN[i])
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (btn_n[i]),
      .level         (level[i]),
      .level_nxt     (level_nxt[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  // Registered from the next-state levels so it changes on the same edge as level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_pressed <= 1'b0;
    else     any_pressed <= |level_nxt;
  end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic [3:0] level, press_pulse, release_pulse, repeat_pulse;
  logic       any_pressed;

  int total = 0;
  int passed = 0;

  button_debouncer #(
    .NUM_BTN(4), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5),
    .REPEAT_EN(4'b0001)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .level(level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {level, press_pulse, release_pulse, repeat_pulse, any_pressed};

  typedef struct {
    logic [3:0] btn_n;
    logic [3:0] lvl, prs, rel, rpt;
    logic       any;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[7];

  initial begin
    int np, nr, nrel, k;
    bit found;

    // Press on btn 0: first sampling edge is E (index 0); accept at E+5.
    for (int i = 0; i < 7; i++) tbl[i] = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[5] = '{4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1};
    tbl[6] = '{4'hE, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};

    // 1. reset
    @(negedge clk); @(negedge clk);
    check("reset_outputs", {15'd0, obs}, 32'd0);
    rst = 1'b0;
    nr = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (obs != 17'd0) nr++;
    end
    check("idle_after_reset", nr, 0);

    // 2. table-driven press on btn 0
    for (int i = 0; i < 7; i++) begin
      btn_n = tbl[i].btn_n;
      tick;
      check($sformatf("press_vec%0d", i), {15'd0, obs},
            {15'd0, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rpt, tbl[i].any});
    end

    // 4. hold: repeats at E+15, E+20, E+25 (P = E+5)
    for (k = 7; k < 25; k++) begin
      tick;
      check($sformatf("hold_e%0d", k), {28'd0, level[0], press_pulse[0], release_pulse[0], repeat_pulse[0]},
            {28'd0, 1'b1, 1'b0, 1'b0, 1'(k == 15 || k == 20)});
    end
    // Release drives before E+25; level falls at E+30, where a repeat would
    // also have been due -- release must win.
    btn_n = 4'hF;
    for (k = 25; k < 46; k++) begin
      tick;
      check($sformatf("rel_e%0d", k), {28'd0, level[0], press_pulse[0], release_pulse[0], repeat_pulse[0]},
            {28'd0, 1'(k < 30), 1'b0, 1'(k == 30), 1'(k == 25)});
    end

    // 3. glitch on btn 1: 3 low cycles invisible, 4 low cycles accepted once
    np = 0; nr = 0;
    btn_n = 4'hD;
    repeat (3) begin tick; np += press_pulse[1]; nr += level[1]; end
    btn_n = 4'hF;
    repeat (12) begin tick; np += press_pulse[1]; nr += level[1]; end
    check("glitch3_press", np, 0);
    check("glitch3_level", nr, 0);
    np = 0; nrel = 0;
    btn_n = 4'hD;
    repeat (4) begin tick; np += press_pulse[1]; nrel += release_pulse[1]; end
    btn_n = 4'hF;
    repeat (12) begin tick; np += press_pulse[1]; nrel += release_pulse[1]; end
    check("glitch4_press", np, 1);
    check("glitch4_release", nrel, 1);
    check("glitch4_level_end", level[1], 0);

    // 5. btn 2 without auto-repeat
    np = 0; nr = 0;
    btn_n = 4'hB;
    repeat (100) begin tick; np += press_pulse[2]; nr += repeat_pulse[2]; end
    check("btn2_press_count", np, 1);
    check("btn2_repeat_count", nr, 0);
    check("btn2_any", {level, any_pressed}, {4'h4, 1'b1});
    btn_n = 4'hF;
    repeat (10) tick;
    check("btn2_released", {level, any_pressed}, 5'd0);

    // 6. reset while btn 0 is in REPEAT
    btn_n = 4'hE;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (press_pulse[0]) found = 1;
    end
    check("pre_rst_press", found, 1);
    repeat (12) tick;  // past first repeat: FSM now in REPEAT
    check("pre_rst_level", level[0], 1);
    rst = 1'b1;
    #1;
    check("rst_async_clear", {15'd0, obs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    found = 0;
    k = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (press_pulse[0]) begin found = 1; k = i; end
      else if (obs != 17'd0) $display("FAIL post_rst_early: obs %0h at edge %0d", obs, i);
    end
    check("post_rst_press_edge", k, 5);
    tick;
    check("post_rst_pulse_width", press_pulse[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
